// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan shift controller and its MISR.
package scan_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, RESP, CAPTURE} state_t;
    typedef enum logic {PAT, FLUSH} mode_t;

    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
    localparam int          PAT_CNT_W = 16;
endpackage

// File: rtl/scan_misr.sv
// Multiple-input signature register compacting the chain scan-out stream.
module scan_misr
    import scan_ctrl_pkg::*;
#(
    parameter int         W    = 32,
    parameter logic [W-1:0] POLY = W'(MISR_POLY)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ W'(din);
        end
    end

endmodule

// File: rtl/scan_shift_ctrl.sv
// Scan load/unload sequencer: shifts patterns into an SDFF chain, unloads responses, pulses capture.
// Optional SO signature compaction is built when SCAN_MISR_EN is defined.
//
//   state   | meaning
//   IDLE    | waiting for a pattern or a flush request
//   SHIFT   | SE=1, chain clocked, pattern in / response out
//   RESP    | response word held for the consumer, chain frozen
//   CAPTURE | SE=0, chain clocked for CAPTURE_CYCLES cycles
module scan_shift_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int   CHAIN_LEN      = 8,
    parameter int   CAPTURE_CYCLES = 1,
    parameter logic FILL_VALUE     = 1'b0,
    parameter int   MISR_W         = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic                 flush,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO,
    output logic                 chain_cen,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [CHAIN_LEN-1:0] resp_data,
    output logic                 busy,
    output logic [PAT_CNT_W-1:0] pat_count,
    output logic [MISR_W-1:0]    signature
);

    localparam int CNT_MAX = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    state_t               state, state_nxt;
    mode_t                mode, mode_nxt;
    logic                 have_prev, have_prev_nxt;
    logic                 armed;
    logic [CHAIN_LEN-1:0] sreg;
    logic [CNT_W-1:0]     cnt;

    always_comb begin
        state_nxt     = state;
        mode_nxt      = mode;
        have_prev_nxt = have_prev;
        case (state)
            IDLE: begin
                // A simultaneous flush is dropped in favour of the pattern.
                if (armed && pat_valid) begin
                    state_nxt = SHIFT;
                    mode_nxt  = PAT;
                end else if (armed && flush && have_prev) begin
                    state_nxt = SHIFT;
                    mode_nxt  = FLUSH;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    if (have_prev)        state_nxt = RESP;
                    else if (mode == PAT) state_nxt = CAPTURE;
                    else                  state_nxt = IDLE;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (mode == PAT) begin
                        state_nxt = CAPTURE;
                    end else begin
                        state_nxt     = IDLE;
                        have_prev_nxt = 1'b0;
                    end
                end
            end
            CAPTURE: begin
                if (cnt == '0) begin
                    state_nxt     = IDLE;
                    have_prev_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            mode      <= PAT;
            have_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode      <= mode_nxt;
            have_prev <= have_prev_nxt;
            armed     <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sreg      <= '0;
            cnt       <= '0;
            pat_count <= '0;
        end else begin
            if (state == IDLE && state_nxt == SHIFT) begin
                sreg <= (mode_nxt == PAT) ? pat_data : {CHAIN_LEN{FILL_VALUE}};
                cnt  <= CNT_W'(CHAIN_LEN - 1);
            end else begin
                if (state == SHIFT)
                    sreg <= {sreg[CHAIN_LEN-2:0], SO};
                if (state_nxt == CAPTURE && state != CAPTURE)
                    cnt <= CNT_W'(CAPTURE_CYCLES - 1);
                else if (cnt != '0)
                    cnt <= cnt - CNT_W'(1);
            end
            if (state == CAPTURE && cnt == '0)
                pat_count <= pat_count + PAT_CNT_W'(1);
        end
    end

    assign busy       = (state != IDLE);
    assign pat_ready  = armed && (state == IDLE);
    assign SE         = (state == SHIFT) || (state == RESP);
    assign chain_cen  = (state == SHIFT) || (state == CAPTURE);
    assign SI         = (state == SHIFT) && sreg[CHAIN_LEN-1];
    assign resp_valid = (state == RESP);
    assign resp_data  = resp_valid ? sreg : '0;

`ifdef SCAN_MISR_EN
    logic misr_en;
    assign misr_en = (state == SHIFT) && have_prev;

    scan_misr #(
        .W    (MISR_W),
        .POLY (MISR_W'(MISR_POLY))
    ) u_misr (
        .clk (CLK),
        .rst (RST),
        .en  (misr_en),
        .din (SO),
        .sig (signature)
    );
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Directed bench for scan_shift_ctrl driving an 8-flop scan chain model whose capture D is ~Q.
module tb_scan_shift_ctrl;
    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         pat_valid, pat_ready, flush;
    logic [N-1:0] pat_data;
    logic         SE, SI, SO, chain_cen;
    logic         resp_valid, resp_ready;
    logic [N-1:0] resp_data;
    logic         busy;
    logic [15:0]  pat_count;
    logic [31:0]  signature;

    logic [N-1:0] chain = '0;
    logic [31:0]  exp_sig;
    int           n_chk = 0;
    int           n_bad = 0;

    scan_shift_ctrl #(
        .CHAIN_LEN      (N),
        .CAPTURE_CYCLES (1),
        .FILL_VALUE     (1'b0),
        .MISR_W         (32)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .pat_valid  (pat_valid),
        .pat_ready  (pat_ready),
        .pat_data   (pat_data),
        .flush      (flush),
        .SE         (SE),
        .SI         (SI),
        .SO         (SO),
        .chain_cen  (chain_cen),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .pat_count  (pat_count),
        .signature  (signature)
    );

    always #5 CLK = ~CLK;

    assign SO = chain[N-1];
    always @(posedge CLK) begin
        if (chain_cen)
            chain <= SE ? {chain[N-2:0], SI} : ~chain;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] misr_fold(input logic [31:0] s, input logic [7:0] w);
        logic [31:0] r;
        r = s;
        for (int i = 7; i >= 0; i--)
            r = {r[30:0], 1'b0} ^ (r[31] ? 32'h04C11DB7 : 32'h0) ^ {31'b0, w[i]};
        return r;
    endfunction

    task automatic start_pat(input logic [N-1:0] d);
        pat_valid = 1'b1;
        pat_data  = d;
        tick();
        pat_valid = 1'b0;
        pat_data  = '0;
    endtask

    task automatic shift_chk(input logic [N-1:0] pat, input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_se"},   32'(SE), 32'd1);
            check({tag, "_cen"},  32'(chain_cen), 32'd1);
            check({tag, "_si"},   32'(SI), 32'(pat[N-1-i]));
            check({tag, "_rv"},   32'(resp_valid), 32'd0);
            check({tag, "_rdy"},  32'(pat_ready), 32'd0);
            tick();
        end
    endtask

    task automatic capture_chk(input string tag);
        check({tag, "_cap_se"},   32'(SE), 32'd0);
        check({tag, "_cap_cen"},  32'(chain_cen), 32'd1);
        check({tag, "_cap_rv"},   32'(resp_valid), 32'd0);
        tick();
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_rdy"},  32'(pat_ready), 32'd1);
        check({tag, "_idle_cen"},  32'(chain_cen), 32'd0);
    endtask

    task automatic reset_zero_chk(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rdy"},  32'(pat_ready), 32'd0);
        check({tag, "_se"},   32'(SE), 32'd0);
        check({tag, "_cen"},  32'(chain_cen), 32'd0);
        check({tag, "_si"},   32'(SI), 32'd0);
        check({tag, "_rv"},   32'(resp_valid), 32'd0);
        check({tag, "_rd"},   32'(resp_data), 32'd0);
        check({tag, "_cnt"},  32'(pat_count), 32'd0);
        check({tag, "_sig"},  signature, 32'd0);
    endtask

    initial begin
        pat_valid  = 1'b0;
        pat_data   = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        RST        = 1'b0;

        // reset asserted between edges
        #2 RST = 1'b1;
        #1 reset_zero_chk("rst0");
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("rst_rel_rdy", 32'(pat_ready), 32'd1);

        // first pattern: no response, capture flips chain to ~A5
        start_pat(8'hA5);
        shift_chk(8'hA5, "p1");
        capture_chk("p1");
        check("p1_cnt",   32'(pat_count), 32'd1);
        check("p1_chain", 32'(chain), 32'h5A);

        // second pattern unloads 5A; consumer stalls 5 cycles
        start_pat(8'h3C);
        shift_chk(8'h3C, "p2");
        for (int k = 0; k < 5; k++) begin
            check("stall_rv",    32'(resp_valid), 32'd1);
            check("stall_rd",    32'(resp_data), 32'h5A);
            check("stall_se",    32'(SE), 32'd1);
            check("stall_cen",   32'(chain_cen), 32'd0);
            check("stall_rdy",   32'(pat_ready), 32'd0);
            check("stall_chain", 32'(chain), 32'h3C);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        capture_chk("p2");
        check("p2_cnt",   32'(pat_count), 32'd2);
        check("p2_chain", 32'(chain), 32'hC3);

        // flush unloads C3, shifts zeros, no capture
        flush = 1'b1;
        tick();
        flush = 1'b0;
        shift_chk(8'h00, "fl");
        check("fl_rv", 32'(resp_valid), 32'd1);
        check("fl_rd", 32'(resp_data), 32'hC3);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("fl_busy",  32'(busy), 32'd0);
        check("fl_cen",   32'(chain_cen), 32'd0);
        check("fl_cnt",   32'(pat_count), 32'd2);
        check("fl_chain", 32'(chain), 32'h00);
`ifdef SCAN_MISR_EN
        exp_sig = misr_fold(misr_fold(32'h0, 8'h5A), 8'hC3);
`else
        exp_sig = 32'h0;
`endif
        check("fl_sig", signature, exp_sig);

        // flush without a held response is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl2_busy", 32'(busy), 32'd0);

        // pattern after flush has nothing to unload
        start_pat(8'h0F);
        shift_chk(8'h0F, "p3");
        capture_chk("p3");
        check("p3_cnt", 32'(pat_count), 32'd3);
        check("p3_sig", signature, exp_sig);

        // reset in the middle of a shift
        start_pat(8'h96);
        tick();
        tick();
        tick();
        check("p4_busy", 32'(busy), 32'd1);
        #3 RST = 1'b1;
        #1 reset_zero_chk("rst1");
        tick();
        RST = 1'b0;
        tick();
        check("rst1_rel_rdy", 32'(pat_ready), 32'd1);

        start_pat(8'hFF);
        shift_chk(8'hFF, "p5");
        capture_chk("p5");
        check("p5_cnt", 32'(pat_count), 32'd1);
        check("p5_sig", signature, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
